// File: rtl/lv1_bus_requester.sv
// lv1_bus_requester: per-core L1-side master for the lv1-lv2 bus.
// Queues up to two miss requests, arbitrates for the bus, drives addr/cmd
// while granted, and returns the lv2 response (or an error) to the L1.
module lv1_bus_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [1:0]        miss_cmd,
    output logic              bus_lv1_lv2_req_proc,
    input  logic              bus_lv1_lv2_gnt_proc,
    output logic [ADDR_W-1:0] bus_addr_out,
    output logic [1:0]        bus_cmd_out,
    output logic              bus_drive,
    input  logic              bus_data_valid,
    input  logic [DATA_W-1:0] bus_data_in,
    input  logic              bus_ack,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_XFER    = 3'd2;
    localparam logic [2:0] S_RESP    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [1:0] CMD_INV = 2'd2;
    localparam logic [1:0] CMD_RSV = 2'd3;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] act_addr;
    logic [1:0]        act_cmd;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    logic [ADDR_W-1:0] fifo_addr [2];
    logic [1:0]        fifo_cmd  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic done;
    logic [ADDR_W-1:0] head_addr;
    logic [1:0]        head_cmd;

    assign fifo_full  = (count == 2'd2);
    assign fifo_empty = (count == 2'd0);
    assign miss_ready = !rst && !fifo_full;
    assign push       = miss_valid && miss_ready;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_cmd   = fifo_cmd[rd_ptr];

    // RELEASE also dispatches a queued request so the next req phase starts
    // right after the mandatory 2-cycle low gap instead of a cycle later.
    assign pop = ((state == S_IDLE) || (state == S_RELEASE)) && !fifo_empty;

    // Completion is qualified by command type: data for reads, ack for invalidate.
    assign done = (act_cmd == CMD_INV) ? bus_ack : bus_data_valid;

    // FIFO storage: written on accepted pushes, no reset needed for payload
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= miss_addr;
            fifo_cmd[wr_ptr]  <= miss_cmd;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Transaction FSM with XFER watchdog counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            act_addr   <= '0;
            act_cmd    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RELEASE: begin
                    state <= S_IDLE;
                    if (pop) begin
                        act_addr <= head_addr;
                        act_cmd  <= head_cmd;
                        if (head_cmd == CMD_RSV) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_lv1_lv2_gnt_proc) begin
                        cnt   <= '0;
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
                    if (done) begin
                        rsp_data_q <= (act_cmd == CMD_INV) ? '0 : bus_data_in;
                        rsp_err_q  <= 1'b0;
                        state      <= S_RESP;
                    end else if (!bus_lv1_lv2_gnt_proc || (cnt == CNT_LAST)) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_RELEASE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_lv1_lv2_req_proc = (state == S_REQ) || (state == S_XFER);
    assign bus_drive            = (state == S_XFER);
    assign bus_addr_out         = bus_drive ? act_addr : '0;
    assign bus_cmd_out          = bus_drive ? act_cmd : '0;
    assign rsp_valid            = (state == S_RESP);
    assign rsp_data             = rsp_valid ? rsp_data_q : '0;
    assign rsp_err              = rsp_valid && rsp_err_q;

endmodule

// File: tb/tb_lv1_bus_requester.sv
// Directed testbench for lv1_bus_requester (TIMEOUT overridden to 8).
module tb_lv1_bus_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic [1:0]  miss_cmd;
    logic        req;
    logic        gnt;
    logic [31:0] bus_addr_out;
    logic [1:0]  bus_cmd_out;
    logic        bus_drive;
    logic        bus_data_valid;
    logic [31:0] bus_data_in;
    logic        bus_ack;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    lv1_bus_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .miss_valid           (miss_valid),
        .miss_ready           (miss_ready),
        .miss_addr            (miss_addr),
        .miss_cmd             (miss_cmd),
        .bus_lv1_lv2_req_proc (req),
        .bus_lv1_lv2_gnt_proc (gnt),
        .bus_addr_out         (bus_addr_out),
        .bus_cmd_out          (bus_cmd_out),
        .bus_drive            (bus_drive),
        .bus_data_valid       (bus_data_valid),
        .bus_data_in          (bus_data_in),
        .bus_ack              (bus_ack),
        .rsp_valid            (rsp_valid),
        .rsp_data             (rsp_data),
        .rsp_err              (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [1:0] c);
        miss_valid = 1'b1;
        miss_addr  = a;
        miss_cmd   = c;
        step();
        miss_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; miss_cmd = '0;
        gnt = 1'b0; bus_data_valid = 1'b0; bus_data_in = '0; bus_ack = 1'b0;
        step(); step();
        checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", miss_ready); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", req); end
        checks++; if (bus_drive !== 1'b0) begin errors++; $display("FAIL rst_drive got %b exp 0", bus_drive); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp got %b exp 0", rsp_valid); end
        checks++; if (bus_addr_out !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus_addr_out); end
        rst = 1'b0;
        #1;
        checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_low got %b exp 1", miss_ready); end
    endtask

    task automatic test_busrd();
        push(32'h100, 2'd0);
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rd_req_idle got %b exp 0", req); end
        step();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rd_req_t1 got %b exp 1", req); end
        step();
        checks++; if (req !== 1'b1 || bus_drive !== 1'b0) begin errors++; $display("FAIL rd_req_wait got req=%b drive=%b exp 1/0", req, bus_drive); end
        step();
        gnt = 1'b1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rd_req_gnt got %b exp 1", req); end
        step();
        checks++; if (bus_drive !== 1'b1 || bus_addr_out !== 32'h100 || bus_cmd_out !== 2'd0)
            begin errors++; $display("FAIL rd_xfer got drive=%b addr=%h cmd=%0d exp 1/100/0", bus_drive, bus_addr_out, bus_cmd_out); end
        step();
        checks++; if (bus_drive !== 1'b1 || req !== 1'b1) begin errors++; $display("FAIL rd_xfer2 got drive=%b req=%b exp 1/1", bus_drive, req); end
        step();
        bus_data_valid = 1'b1; bus_data_in = 32'hDEADBEEF;
        checks++; if (bus_drive !== 1'b1) begin errors++; $display("FAIL rd_xfer3 got %b exp 1", bus_drive); end
        step();
        bus_data_valid = 1'b0; gnt = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rsp_data got %h exp deadbeef", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp_err got %b exp 0", rsp_err); end
        checks++; if (req !== 1'b0 || bus_drive !== 1'b0) begin errors++; $display("FAIL rd_rsp_bus got req=%b drive=%b exp 0/0", req, bus_drive); end
        step();
        checks++; if (rsp_valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL rd_release got rsp=%b req=%b exp 0/0", rsp_valid, req); end
        step();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rd_idle got %b exp 0", req); end
    endtask

    task automatic test_reserved_cmd();
        push(32'h300, 2'd3);
        checks++; if (req !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rsv_c1 got req=%b rsp=%b exp 0/0", req, rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0 || req !== 1'b0)
            begin errors++; $display("FAIL rsv_rsp got v=%b e=%b d=%h req=%b exp 1/1/0/0", rsp_valid, rsp_err, rsp_data, req); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsv_pulse got %b exp 0", rsp_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        int nrsp = 0;
        int low_run = 0;
        logic prev_req;
        logic a3_acc = 1'b0;
        logic clear_valid;
        addrs[0] = 32'h1000; addrs[1] = 32'h2004; addrs[2] = 32'h3008; addrs[3] = 32'h400C;
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            miss_valid = 1'b1; miss_addr = addrs[i]; miss_cmd = 2'(i % 2);
            checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_push%0d got %b exp 1", i, miss_ready); end
            step();
        end
        miss_valid = 1'b0;
        checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b exp 0", miss_ready); end
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL b2b_req got %b exp 1", req); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_hold got %b exp 0", miss_ready); end
        end
        miss_valid = 1'b1; miss_addr = addrs[3]; miss_cmd = 2'd0;
        prev_req = req;
        for (int cyc = 0; cyc < 80 && nrsp < 4; cyc++) begin
            clear_valid = 1'b0;
            if (req) begin
                if (!prev_req) begin
                    checks++;
                    if (low_run < 2) begin errors++; $display("FAIL b2b_gap got %0d exp >=2", low_run); end
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_req = req;
            if (miss_valid && miss_ready) begin
                a3_acc = 1'b1; clear_valid = 1'b1;
                checks++; if (nrsp < 1) begin errors++; $display("FAIL b2b_ready_early got rsps=%0d exp >=1", nrsp); end
            end
            if (rsp_valid) begin
                checks++;
                if (rsp_data !== (addrs[nrsp] ^ 32'hA5A50000) || rsp_err !== 1'b0)
                    begin errors++; $display("FAIL b2b_rsp%0d got %h err=%b exp %h err=0", nrsp, rsp_data, rsp_err, addrs[nrsp] ^ 32'hA5A50000); end
                nrsp++;
            end
            gnt = req;
            bus_data_valid = bus_drive;
            bus_data_in = bus_addr_out ^ 32'hA5A50000;
            step();
            if (clear_valid) miss_valid = 1'b0;
        end
        gnt = 1'b0; bus_data_valid = 1'b0; miss_valid = 1'b0;
        checks++; if (nrsp !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", nrsp); end
        checks++; if (a3_acc !== 1'b1) begin errors++; $display("FAIL b2b_a3_accept got %b exp 1", a3_acc); end
        step(); step(); step();
    endtask

    task automatic test_timeout();
        int xc = 0;
        logic seen = 1'b0;
        push(32'h400, 2'd2);
        gnt = 1'b1;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            if (rsp_valid) seen = 1'b1;
            else begin
                if (bus_drive) xc++;
                step();
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL to_seen got %b exp 1", seen); end
        checks++; if (xc !== 8) begin errors++; $display("FAIL to_cycles got %0d exp 8", xc); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL to_rsp got err=%b data=%h exp 1/0", rsp_err, rsp_data); end
        checks++; if (req !== 1'b0 || bus_drive !== 1'b0) begin errors++; $display("FAIL to_bus got req=%b drive=%b exp 0/0", req, bus_drive); end
        gnt = 1'b0;
        step(); step();
    endtask

    task automatic test_gnt_drop();
        logic seen = 1'b0;
        push(32'h500, 2'd0);
        gnt = 1'b1;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (bus_drive) seen = 1'b1; else step();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL gd_xfer got %b exp 1", seen); end
        step();
        gnt = 1'b0;
        checks++; if (bus_drive !== 1'b1) begin errors++; $display("FAIL gd_drive got %b exp 1", bus_drive); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0)
            begin errors++; $display("FAIL gd_rsp got v=%b e=%b d=%h exp 1/1/0", rsp_valid, rsp_err, rsp_data); end
        checks++; if (bus_drive !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL gd_bus got drive=%b req=%b exp 0/0", bus_drive, req); end
        step();
        checks++; if (rsp_valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL gd_release got rsp=%b req=%b exp 0/0", rsp_valid, req); end
        step();
        checks++; if (req !== 1'b0 || miss_ready !== 1'b1) begin errors++; $display("FAIL gd_idle got req=%b ready=%b exp 0/1", req, miss_ready); end
    endtask

    task automatic test_reset_mid_xfer();
        logic seen = 1'b0;
        push(32'h600, 2'd1);
        gnt = 1'b1;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (bus_drive) seen = 1'b1; else step();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rx_xfer got %b exp 1", seen); end
        push(32'h700, 2'd0);
        rst = 1'b1;
        step();
        rst = 1'b0; gnt = 1'b0;
        #1;
        checks++; if (req !== 1'b0 || bus_drive !== 1'b0 || rsp_valid !== 1'b0)
            begin errors++; $display("FAIL rx_outputs got req=%b drive=%b rsp=%b exp 0/0/0", req, bus_drive, rsp_valid); end
        checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL rx_ready got %b exp 1", miss_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (req !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rx_fifo_empty got req=%b rsp=%b exp 0/0", req, rsp_valid); end
        end
    endtask

    task automatic test_ack_timeout();
        int xc = 0;
        logic hit = 1'b0;
        push(32'h800, 2'd2);
        gnt = 1'b1;
        for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
            if (bus_drive) xc++;
            if (xc == 8) begin bus_ack = 1'b1; hit = 1'b1; end
            else step();
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL at_reach got %b exp 1", hit); end
        step();
        bus_ack = 1'b0; gnt = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0)
            begin errors++; $display("FAIL at_rsp got v=%b e=%b d=%h exp 1/0/0", rsp_valid, rsp_err, rsp_data); end
        step(); step();
    endtask

    task automatic test_stray_data();
        bus_data_valid = 1'b1; bus_data_in = 32'hFFFF0000; bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rsp_valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL stray got rsp=%b req=%b exp 0/0", rsp_valid, req); end
        end
        bus_data_valid = 1'b0; bus_ack = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stray_after got %b exp 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_busrd();
        test_reserved_cmd();
        test_back_to_back();
        test_timeout();
        test_gnt_drop();
        test_reset_mid_xfer();
        test_ack_timeout();
        test_stray_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
